bus_addr_decoder: RTL and testbench

Bus-side address decoder that sits directly upstream of every slave wrapper on the serial bus. It receives the granted master's serial stream and shifts in the device-select field that precedes each frame. It then acknowledges or rejects the target, and forwards the rest of the frame only to the selected slave's `mvalid`/`swdata` pins. Read data and valid from the selected slave are muxed back to the master, and the selection is held across split transactions.

---
 rtl/bus_addr_decoder.sv | 113 +++++++++++
 tb/tb_bus_addr_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_addr_decoder.sv
// Serial device-select decoder: shifts in an LSB-first target index, acks or rejects it,
// then forwards the frame to the chosen slave and muxes its read path back to the master.
module bus_addr_decoder #(
  parameter int NUM_SLAVES = 3,
  parameter int DEV_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bgrant,
  input  logic                  mwdata,
  input  logic                  mvalid,
  output logic                  m_ack_valid,
  output logic                  m_ack,
  output logic                  m_srdata,
  output logic                  m_svalid,
  output logic                  split_pending,
  output logic [NUM_SLAVES-1:0] s_mvalid,
  output logic                  s_swdata,
  input  logic [NUM_SLAVES-1:0] s_sready,
  input  logic [NUM_SLAVES-1:0] s_svalid,
  input  logic [NUM_SLAVES-1:0] s_srdata,
  input  logic [NUM_SLAVES-1:0] s_ssplit,
  output logic [DEV_BITS-1:0]   sel
);

  localparam int CW = $clog2(DEV_BITS + 1);

  typedef enum logic [2:0] {IDLE, ADDR, CHECK, FORWARD, SPLIT, NACK} state_t;

  state_t              state, state_nx;
  logic [DEV_BITS-1:0] dev;
  logic [CW-1:0]       cnt;
  logic                bit_in;
  logic                accept;
  logic                sel_split, sel_rd, sel_vld, rd_en;

  assign bit_in = mvalid & bgrant;

  // Index by comparison so codes >= NUM_SLAVES match nothing and are rejected.
  always_comb begin
    accept    = 1'b0;
    sel_split = 1'b0;
    sel_rd    = 1'b0;
    sel_vld   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dev == DEV_BITS'(i)) accept = s_sready[i];
      if (sel == DEV_BITS'(i)) begin
        sel_split = s_ssplit[i];
        sel_rd    = s_srdata[i];
        sel_vld   = s_svalid[i];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bit_in) state_nx = (DEV_BITS == 1) ? CHECK : ADDR;
      ADDR:    if (!bit_in) state_nx = IDLE;
               else if (cnt == CW'(DEV_BITS - 1)) state_nx = CHECK;
      CHECK:   state_nx = accept ? FORWARD : NACK;
      FORWARD: if (!bgrant) state_nx = sel_split ? SPLIT : IDLE;
      SPLIT:   if (bgrant) state_nx = FORWARD;
      NACK:    if (!bgrant) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dev      <= '0;
      cnt      <= '0;
      sel      <= '0;
      s_mvalid <= '0;
      s_swdata <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bit_in) begin
          dev    <= '0;
          dev[0] <= mwdata;
          cnt    <= CW'(1);
        end
        ADDR: if (bit_in) begin
          for (int i = 0; i < DEV_BITS; i++)
            if (cnt == CW'(i)) dev[i] <= mwdata;
          cnt <= cnt + CW'(1);
        end else begin
          dev <= '0;
          cnt <= '0;
        end
        CHECK: begin
          cnt <= '0;
          if (accept) sel <= dev;
        end
        default: ;
      endcase
      // One-cycle forward register; anything outside FORWARD drains to zero.
      for (int i = 0; i < NUM_SLAVES; i++)
        s_mvalid[i] <= (state == FORWARD) && mvalid && (sel == DEV_BITS'(i));
      s_swdata <= (state == FORWARD) && mvalid && mwdata;
    end
  end

  assign m_ack_valid   = (state == CHECK);
  assign m_ack         = (state == CHECK) && accept;
  assign split_pending = (state == SPLIT);
  assign rd_en         = (state == FORWARD) || (state == SPLIT);
  assign m_srdata      = rd_en && sel_rd;
  assign m_svalid      = rd_en && sel_vld;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed bench for bus_addr_decoder: accept, reject, read return, split, abort, reset.
module tb_bus_addr_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       bgrant, mwdata, mvalid;
  logic       m_ack_valid, m_ack, m_srdata, m_svalid, split_pending;
  logic [2:0] s_mvalid;
  logic       s_swdata;
  logic [2:0] s_sready, s_svalid, s_srdata, s_ssplit;
  logic [1:0] sel;

  int checks = 0;
  int errors = 0;

  bus_addr_decoder #(.NUM_SLAVES(3), .DEV_BITS(2)) dut (
    .clk(clk), .rst(rst), .bgrant(bgrant), .mwdata(mwdata), .mvalid(mvalid),
    .m_ack_valid(m_ack_valid), .m_ack(m_ack), .m_srdata(m_srdata), .m_svalid(m_svalid),
    .split_pending(split_pending), .s_mvalid(s_mvalid), .s_swdata(s_swdata),
    .s_sready(s_sready), .s_svalid(s_svalid), .s_srdata(s_srdata), .s_ssplit(s_ssplit),
    .sel(sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Send two device bits LSB first; on return the DUT is in the check cycle.
  task automatic send_dev(input logic [1:0] d);
    bgrant = 1'b1; mvalid = 1'b1; mwdata = d[0];
    tick();
    mwdata = d[1];
    tick();
    mvalid = 1'b0; mwdata = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {m_ack_valid, m_ack, m_srdata, m_svalid, split_pending, s_mvalid, s_swdata},
        '0);
  endtask

  logic [19:0] wdata;
  logic [7:0]  rpat;

  initial begin
    rst = 1'b1; bgrant = 1'b0; mwdata = 1'b0; mvalid = 1'b0;
    s_sready = '0; s_svalid = '0; s_srdata = '0; s_ssplit = '0;
    wdata = 20'hB3C5A; rpat = 8'hA5;
    #1;
    chk_all_zero("reset");
    chk("reset.sel", sel, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Accepted write to slave 2
    s_sready = 3'b111;
    send_dev(2'd2);
    chk("wr.ack_valid", m_ack_valid, 1);
    chk("wr.ack", m_ack, 1);
    tick();
    chk("wr.ack_valid_pulse", m_ack_valid, 0);
    chk("wr.sel", sel, 2);
    for (int i = 0; i < 20; i++) begin
      mvalid = 1'b1; mwdata = wdata[i];
      if (i == 10) s_sready = 3'b000;
      tick();
      chk($sformatf("wr.s_mvalid[%0d]", i), s_mvalid, 3'b100);
      chk($sformatf("wr.s_swdata[%0d]", i), s_swdata, wdata[i]);
    end
    bgrant = 1'b0; mvalid = 1'b0; mwdata = 1'b0;
    tick();
    chk("wr.end_mvalid", s_mvalid, 0);
    s_svalid = 3'b111; s_srdata = 3'b111;
    #1;
    chk("idle.m_svalid_gated", m_svalid, 0);
    chk("idle.m_srdata_gated", m_srdata, 0);

    // Reject out-of-range dev=3
    s_sready = 3'b111;
    send_dev(2'd3);
    chk("rej3.ack_valid", m_ack_valid, 1);
    chk("rej3.ack", m_ack, 0);
    tick();
    mvalid = 1'b1; mwdata = 1'b1;
    tick();
    chk("rej3.s_mvalid", s_mvalid, 0);
    chk("rej3.m_svalid", m_svalid, 0);
    tick();
    chk("rej3.s_mvalid2", s_mvalid, 0);
    chk("rej3.ack_valid_off", m_ack_valid, 0);
    bgrant = 1'b0; mvalid = 1'b0; mwdata = 1'b0;
    tick();

    // Reject dev=1 with slave 1 not ready
    s_sready = 3'b101;
    send_dev(2'd1);
    chk("rej1.ack_valid", m_ack_valid, 1);
    chk("rej1.ack", m_ack, 0);
    tick();
    bgrant = 1'b0;
    tick();
    s_svalid = '0; s_srdata = '0;

    // Read return from slave 0, others toggling
    s_sready = 3'b111;
    send_dev(2'd0);
    chk("rd.ack", m_ack, 1);
    tick();
    chk("rd.sel", sel, 0);
    for (int i = 0; i < 8; i++) begin
      s_svalid = {i[1], i[0], 1'b1};
      s_srdata = {~i[0], i[1], rpat[i]};
      #1;
      chk($sformatf("rd.m_srdata[%0d]", i), m_srdata, rpat[i]);
      chk($sformatf("rd.m_svalid[%0d]", i), m_svalid, 1);
      tick();
    end
    s_svalid = 3'b110; s_srdata = 3'b111;
    #1;
    chk("rd.svalid_low", m_svalid, 0);
    bgrant = 1'b0;
    tick();
    s_svalid = '0; s_srdata = '0;

    // Split on slave 1
    send_dev(2'd1);
    chk("sp.ack", m_ack, 1);
    tick();
    mvalid = 1'b1; mwdata = 1'b1;
    tick();
    chk("sp.s_mvalid", s_mvalid, 3'b010);
    s_ssplit = 3'b010; bgrant = 1'b0; mvalid = 1'b0; mwdata = 1'b0;
    tick();
    chk("sp.pending", split_pending, 1);
    chk("sp.sel", sel, 1);
    chk("sp.s_mvalid0", s_mvalid, 0);
    s_srdata = 3'b010; s_svalid = 3'b010;
    tick();
    chk("sp.pending_held", split_pending, 1);
    chk("sp.rd_valid", m_svalid, 1);
    chk("sp.rd_data", m_srdata, 1);
    bgrant = 1'b1;
    tick();
    chk("sp.resume", split_pending, 0);
    mvalid = 1'b1; mwdata = 1'b1;
    tick();
    chk("sp.fwd_mvalid", s_mvalid, 3'b010);
    chk("sp.fwd_swdata", s_swdata, 1);
    s_srdata = 3'b101;
    #1;
    chk("sp.rd_data0", m_srdata, 0);
    s_ssplit = '0; bgrant = 1'b0; mvalid = 1'b0; mwdata = 1'b0;
    tick();
    chk("sp.idle_pending", split_pending, 0);
    chk("sp.idle_svalid", m_svalid, 0);
    s_srdata = '0; s_svalid = '0;

    // Abort after one of two device bits
    bgrant = 1'b1; mvalid = 1'b1; mwdata = 1'b1;
    tick();
    mvalid = 1'b0; mwdata = 1'b0;
    chk("ab.no_ack0", m_ack_valid, 0);
    tick();
    chk("ab.no_ack1", m_ack_valid, 0);
    tick();
    chk("ab.no_ack2", m_ack_valid, 0);
    send_dev(2'd2);
    chk("ab.next_ack_valid", m_ack_valid, 1);
    chk("ab.next_ack", m_ack, 1);
    tick();
    chk("ab.next_sel", sel, 2);

    // Reset in the middle of forwarding to slave 2
    s_svalid = 3'b111; s_srdata = 3'b111;
    mvalid = 1'b1; mwdata = 1'b1;
    tick();
    chk("rs.s_mvalid", s_mvalid, 3'b100);
    chk("rs.m_svalid", m_svalid, 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rs.async");
    chk("rs.sel", sel, 0);
    bgrant = 1'b0; mvalid = 1'b0; mwdata = 1'b0;
    tick();
    rst = 1'b0;
    send_dev(2'd0);
    chk("rs.after_ack_valid", m_ack_valid, 1);
    chk("rs.after_ack", m_ack, 1);
    tick();
    chk("rs.after_sel", sel, 0);
    chk("rs.after_rd", m_srdata, 1);
    bgrant = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
